// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the 8N1 UART receiver.
`timescale 1ns/1ps
package serial_pkg;

    localparam int DEFAULT_CLK_HZ = 100_000_000;
    localparam int DEFAULT_BAUD   = 115_200;
    localparam int CLKS_PER_BIT   = DEFAULT_CLK_HZ / DEFAULT_BAUD;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle (high) level.
`timescale 1ns/1ps
module serial_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial.sv
// UART receiver, 8N1, LSB first: samples each bit at mid-period and strobes
// rbyte_ready for one clock when a correctly framed byte lands in rx_byte.
`timescale 1ns/1ps
module serial
    import serial_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rbyte_ready,
    output logic [3:0] onum_bits
);

    localparam int BIT_CLKS  = CLK_HZ / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CNT_W     = $clog2(BIT_CLKS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shift_reg;
    logic             rx_s;
    logic             rx_prev;

    serial_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // A start edge is a falling transition on the synchronized line seen while IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            onum_bits   <= '0;
            shift_reg   <= '0;
            rx_byte     <= '0;
            rbyte_ready <= 1'b0;
            rx_prev     <= 1'b1;
        end else begin
            rbyte_ready <= 1'b0;
            rx_prev     <= rx_s;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state     <= DATA;
                            onum_bits <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt                      <= '0;
                        shift_reg[onum_bits[2:0]] <= rx_s;
                        onum_bits                <= onum_bits + 4'd1;
                        if (onum_bits == 4'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_byte     <= shift_reg;
                            rbyte_ready <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    // Hold off until the line returns high so a break is not read as a start.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial.sv
// Directed bench for the serial UART receiver, run at 32 clocks per bit (320 ns bits).
`timescale 1ns/1ps
module tb_serial;
    import serial_pkg::*;

    localparam int BIT_NS = 320;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rbyte_ready;
    logic [3:0] onum_bits;

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         dbl_pulses = 0;
    int         stray_changes = 0;
    time        last_pulse_t = 0;
    logic [7:0] got_bytes[$];
    logic       prev_rdy = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    serial #(
        .CLK_HZ (100_000_000),
        .BAUD   (3_125_000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .rx_byte     (rx_byte),
        .rbyte_ready (rbyte_ready),
        .onum_bits   (onum_bits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy  = 1'b0;
            prev_byte = rx_byte;
        end else begin
            if (rbyte_ready) begin
                pulses++;
                got_bytes.push_back(rx_byte);
                last_pulse_t = $time;
                if (prev_rdy) dbl_pulses++;
            end
            if (rx_byte !== prev_byte && !rbyte_ready) stray_changes++;
            prev_rdy  = rbyte_ready;
            prev_byte = rx_byte;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] byteAt(input int idx);
        if (idx < got_bytes.size()) return got_bytes[idx];
        return 8'hxx;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int bit_ns, input logic stop_val);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            #(bit_ns);
        end
        rx = stop_val;
        #(bit_ns);
    endtask

    initial begin
        int  base;
        time t_start;
        time latency;

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_byte", 32'(rx_byte), 32'h00);
        checkOutput("reset_ready", 32'(rbyte_ready), 32'h0);
        checkOutput("reset_num_bits", 32'(onum_bits), 32'h0);
        rst_n = 1'b1;
        #2000;

        base    = pulses;
        t_start = $time;
        applyStimulus(8'h53, BIT_NS, 1'b1);
        #(BIT_NS);
        latency = last_pulse_t - t_start;
        $display("[TB] first frame latency %0t ns", latency);
        checkOutput("f53_pulses", 32'(pulses - base), 32'd1);
        checkOutput("f53_byte", 32'(byteAt(base)), 32'h53);
        checkOutput("f53_num_bits", 32'(onum_bits), 32'd8);
        checkOutput("f53_latency", 32'(latency >= 3040 && latency <= 3120), 32'd1);

        base = pulses;
        applyStimulus(8'h00, BIT_NS, 1'b1);
        applyStimulus(8'hFF, BIT_NS, 1'b1);
        applyStimulus(8'h35, BIT_NS, 1'b1);
        #(BIT_NS);
        checkOutput("b2b_pulses", 32'(pulses - base), 32'd3);
        checkOutput("b2b_byte0", 32'(byteAt(base)), 32'h00);
        checkOutput("b2b_byte1", 32'(byteAt(base + 1)), 32'hFF);
        checkOutput("b2b_byte2", 32'(byteAt(base + 2)), 32'h35);

        base = pulses;
        rx = 1'b0;
        #100;
        rx = 1'b1;
        #1000;
        checkOutput("glitch_pulses", 32'(pulses - base), 32'd0);
        checkOutput("glitch_rx_byte", 32'(rx_byte), 32'h35);
        checkOutput("glitch_state", 32'(dut.state), 32'(IDLE));
        checkOutput("glitch_num_bits", 32'(onum_bits), 32'd8);

        base = pulses;
        applyStimulus(8'hA5, BIT_NS, 1'b0);
        #2000;
        checkOutput("ferr_pulses", 32'(pulses - base), 32'd0);
        checkOutput("ferr_rx_byte", 32'(rx_byte), 32'h35);
        checkOutput("ferr_state", 32'(dut.state), 32'(WAIT_IDLE));
        rx = 1'b1;
        #(2 * BIT_NS);
        base = pulses;
        applyStimulus(8'h3C, BIT_NS, 1'b1);
        #(BIT_NS);
        checkOutput("after_ferr_pulses", 32'(pulses - base), 32'd1);
        checkOutput("after_ferr_byte", 32'(byteAt(base)), 32'h3C);

        base = pulses;
        fork
            applyStimulus(8'h53, BIT_NS, 1'b1);
            begin
                #(5 * BIT_NS + BIT_NS / 2);
                rst_n = 1'b0;
                #30;
                checkOutput("midrst_rx_byte", 32'(rx_byte), 32'h00);
                checkOutput("midrst_ready", 32'(rbyte_ready), 32'h0);
                checkOutput("midrst_num_bits", 32'(onum_bits), 32'h0);
                #(9 * BIT_NS + BIT_NS / 2 - (5 * BIT_NS + BIT_NS / 2) - 30);
                rst_n = 1'b1;
            end
        join
        #(2 * BIT_NS);
        checkOutput("midrst_pulses", 32'(pulses - base), 32'd0);
        base = pulses;
        applyStimulus(8'h77, BIT_NS, 1'b1);
        #(BIT_NS);
        checkOutput("f77_pulses", 32'(pulses - base), 32'd1);
        checkOutput("f77_byte", 32'(byteAt(base)), 32'h77);

        base = pulses;
        applyStimulus(8'hC3, 330, 1'b1);
        #330;
        checkOutput("slow_pulses", 32'(pulses - base), 32'd1);
        checkOutput("slow_byte", 32'(byteAt(base)), 32'hC3);

        checkOutput("double_pulse", 32'(dbl_pulses), 32'd0);
        checkOutput("stray_byte_change", 32'(stray_changes), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial.md
Name: serial

Overview:
- UART receiver, 8N1, LSB first. Idle line is high.
- Converts the asynchronous `rx` line into parallel bytes, with a one-clock strobe per good byte.
- Sits between the external serial pin and the byte-consuming logic, for example the 7-segment display command decoder.
- Runs at 100 MHz system clock, 115200 baud by default (bit period 8.68 µs = 868 clocks).

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (868), clocks per bit; derived, never overridden independently.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line; idle high.
- rx_byte  output  8  last correctly framed byte; holds until the next good byte.
- rbyte_ready  output  1  one-clock pulse when rx_byte is updated.
- onum_bits  output  4  data bits captured in the current or last frame, 0..8 (debug/status).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State returns to IDLE.
  - rx_byte=0x00, rbyte_ready=0, onum_bits=0, counters=0.
  - Synchronizer flops are set to 1.
  - Reset in mid-frame abandons the frame; no pulse is generated.
- Input synchronizer: rx passes through 2 flip-flops before any use. All timing below counts from the synchronized signal.
- Bit counter counts 0..CLKS_PER_BIT-1.
- State machine:
  - IDLE: onum_bits holds its value. A high-to-low transition on synced rx goes to START and clears the counter.
  - START: wait CLKS_PER_BIT/2 clocks (434), then sample.
    - Sample low: go to DATA, clear onum_bits, counter restarts.
    - Sample high: treat as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT clocks, sample rx into shift register bit onum_bits (LSB first) and increment onum_bits. After the 8th sample (onum_bits=8) go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample.
    - Sample high: load rx_byte with the shift register, assert rbyte_ready for exactly 1 clock, go to IDLE.
    - Sample low (framing error): rx_byte unchanged, no pulse, go to WAIT_IDLE.
  - WAIT_IDLE: stay until synced rx=1, then go to IDLE. This prevents false restarts on a break condition.
- Latency: rbyte_ready rises 9.5 bit times after the start falling edge at the pin, plus 2–3 clocks of synchronizer/registration. That is about 8246 clocks (≈82.5 µs) at the defaults.
- Sampling is at mid-bit, so the design tolerates ±4% baud mismatch.
- Back-to-back frames: a new start edge is accepted on the first clock after returning to IDLE. A stop bit of one full bit time is sufficient.
- rbyte_ready never asserts for two consecutive clocks.
- rx_byte changes only in the same cycle that rbyte_ready is high.

Decomposition:
- Shared package (serial_pkg):
  - CLK_HZ and BAUD defaults.
  - CLKS_PER_BIT and HALF_BIT constants.
  - State enum: IDLE, START, DATA, STOP, WAIT_IDLE.
- One natural sub-module: serial_sync, a 2-FF synchronizer with reset-to-1.
- Everything else (counters, FSM, shift register) stays in serial.

Test Plan:
- Stimulus: rx held high 200 µs, then frame 0x53 at 8680 ns/bit (bits 1,1,0,0,1,0,1,0 LSB first).
  - Required: one rbyte_ready pulse, rx_byte=0x53 at the pulse, pulse ≈82.5 µs after the start edge, onum_bits=8 afterwards.
- Stimulus: frames 0x00, then 0xFF, then 0x35 back-to-back with a 1-bit stop only.
  - Required: three pulses, rx_byte=0x00, 0xFF, 0x35 in order, no spurious pulses.
- Stimulus: rx low for 2 µs (shorter than half a bit), then high.
  - Required: no pulse, rx_byte unchanged, FSM back in IDLE.
- Stimulus: frame 0xA5 with the stop bit driven low, then rx held low 50 µs, then high, then frame 0x3C.
  - Required: no pulse for 0xA5, rx_byte keeps its previous value, then a pulse with rx_byte=0x3C.
- Stimulus: pulse rst_n low mid-frame (after 4 data bits of 0x53) while the line continues.
  - Required: outputs zero during reset, no pulse for the truncated frame, and the next full frame 0x77 is received correctly.
- Stimulus: frame 0xC3 at a bit period 3% long (8940 ns).
  - Required: rx_byte=0xC3 with one pulse.
